instr_fetch: RTL and testbench

Instruction fetch unit: the initiator side of the synchronous-read instruction ROM. It generates sequential ROM addresses, absorbs the ROM's fixed one-cycle read latency, and presents instruction/address pairs to the decode stage over a valid/ready handshake. It supports back-pressure and branch/jump redirects. It sits between the instruction ROM and the decoder.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instr_fetch_if.sv | 50 +++++
 rtl/fetch_skid_fifo.sv | 89 ++++++++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and types for the instruction fetch unit.
//               FETCH_FIFO_DEPTH - depth of the fetch skid FIFO
//               fifo_count_t     - occupancy count type (0..FETCH_FIFO_DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int FETCH_FIFO_DEPTH = 2;
  localparam int FETCH_CNT_W      = $clog2(FETCH_FIFO_DEPTH + 1);

  typedef logic [FETCH_CNT_W-1:0] fifo_count_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bus bundle between the fetch unit, the instruction ROM,
//               the redirect source and the decoder.
//               master : fetch unit side (drives rom_address, instr_*)
//               slave  : environment side (drives rom_data, redirect_*,
//                        instr_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int DATA_LENGTH = 32,
  parameter int MEM_LENGTH  = 32
);

  localparam int AW = $clog2(MEM_LENGTH);

  logic [AW-1:0]          rom_address;
  logic [DATA_LENGTH-1:0] rom_data;
  logic                   redirect_valid;
  logic [AW-1:0]          redirect_address;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [DATA_LENGTH-1:0] instr_data;
  logic [AW-1:0]          instr_address;

  modport master (
    output rom_address,
    input  rom_data,
    input  redirect_valid,
    input  redirect_address,
    output instr_valid,
    input  instr_ready,
    output instr_data,
    output instr_address
  );

  modport slave (
    input  rom_address,
    output rom_data,
    output redirect_valid,
    output redirect_address,
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    input  instr_address
  );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_fifo
// Description : 2-entry synchronous FIFO of {address, data} pairs.
//               Entry 0 is always the head, so the head outputs come
//               straight from a register.
//   clk, rst          - clock, synchronous active-high reset
//   i_push, i_push_*  - write an entry
//   i_pop             - remove the head entry
//   i_flush           - drop all entries (wins over push/pop)
//   o_count           - number of valid entries
//   o_head_*          - head entry contents
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_address,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fifo_count_t   o_count,
  output logic [AW-1:0] o_head_address,
  output logic [DW-1:0] o_head_data
);

  typedef struct packed {
    logic [AW-1:0] address;
    logic [DW-1:0] data;
  } fetch_entry_t;

  localparam fifo_count_t c_FULL = fifo_count_t'(FETCH_FIFO_DEPTH);

  fetch_entry_t r_entry0;
  fetch_entry_t r_entry1;
  fifo_count_t  r_count;
  fetch_entry_t w_in;
  logic         w_pop;
  logic         w_push;

  assign w_in   = '{address: i_push_address, data: i_push_data};
  // Guard against pops of an empty FIFO and pushes into a full one.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != c_FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_count  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == '0) r_entry0 <= w_in;
          else               r_entry1 <= w_in;
          r_count <= r_count + 1'b1;
        end
        2'b01: begin
          r_entry0 <= r_entry1;
          r_count  <= r_count - 1'b1;
        end
        2'b11: begin
          // Count unchanged; new entry lands behind whatever remains.
          if (r_count == fifo_count_t'(1)) begin
            r_entry0 <= w_in;
          end else begin
            r_entry0 <= r_entry1;
            r_entry1 <= w_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count        = r_count;
  assign o_head_address = r_entry0.address;
  assign o_head_data    = r_entry0.data;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Drives sequential addresses to a
//               synchronous-read ROM, absorbs its one-cycle latency and
//               hands {address, instruction} pairs to the decoder over a
//               valid/ready handshake, with back-pressure and redirects.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - instr_fetch_if.master: rom_address/rom_data,
//               redirect_valid/redirect_address,
//               instr_valid/instr_ready/instr_data/instr_address
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int MEM_LENGTH  = 32,
  parameter int RESET_PC    = 0
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);

  localparam int            AW         = $clog2(MEM_LENGTH);
  localparam logic [AW-1:0] c_LAST_PC  = AW'(MEM_LENGTH - 1);
  localparam logic [AW-1:0] c_RESET_PC = AW'(RESET_PC);

  logic [AW-1:0]          r_pc;
  logic                   r_inflight;
  logic [AW-1:0]          r_inflight_addr;

  fifo_count_t            w_count;
  logic [AW-1:0]          w_head_address;
  logic [DATA_LENGTH-1:0] w_head_data;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_issue;
  logic [2:0]             w_occupancy;
  logic [2:0]             w_limit;
  logic [AW-1:0]          w_next_pc;
  logic [AW-1:0]          w_redirect_pc;

  assign bus.instr_valid = (w_count != '0);
  assign w_pop           = bus.instr_valid && bus.instr_ready;

  // Issue only if the new word is guaranteed a FIFO slot when it returns:
  // count + inflight - pop < depth, rearranged to avoid underflow.
  assign w_occupancy = 3'(w_count) + 3'(r_inflight);
  assign w_limit     = 3'(FETCH_FIFO_DEPTH) + 3'(w_pop);
  assign w_issue     = !bus.redirect_valid && (w_occupancy < w_limit);

  // Explicit wrap so non-power-of-two ROM depths work.
  assign w_next_pc     = (r_pc == c_LAST_PC) ? '0 : r_pc + 1'b1;
  assign w_redirect_pc = (32'(bus.redirect_address) >= 32'(MEM_LENGTH))
                         ? '0 : bus.redirect_address;

  // The word returning in a redirect cycle belongs to the old stream.
  assign w_push = r_inflight && !bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc            <= c_RESET_PC;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else if (bus.redirect_valid) begin
      r_pc            <= w_redirect_pc;
      r_inflight      <= 1'b0;
    end else if (w_issue) begin
      r_pc            <= w_next_pc;
      r_inflight      <= 1'b1;
      r_inflight_addr <= r_pc;
    end else begin
      r_inflight      <= 1'b0;
    end
  end

  fetch_skid_fifo #(
    .AW (AW),
    .DW (DATA_LENGTH)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .i_push         (w_push),
    .i_push_address (r_inflight_addr),
    .i_push_data    (bus.rom_data),
    .i_pop          (w_pop),
    .i_flush        (bus.redirect_valid),
    .o_count        (w_count),
    .o_head_address (w_head_address),
    .o_head_data    (w_head_data)
  );

  assign bus.rom_address   = r_pc;
  assign bus.instr_data    = w_head_data;
  assign bus.instr_address = w_head_address;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch. Two instances:
//               A with MEM_LENGTH=32, B with MEM_LENGTH=24. Each ROM model
//               returns mem[i] = i + 100 one cycle after the address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch_if #(.DATA_LENGTH(32), .MEM_LENGTH(32)) bus_a ();
  instr_fetch_if #(.DATA_LENGTH(32), .MEM_LENGTH(24)) bus_b ();

  instr_fetch #(.DATA_LENGTH(32), .MEM_LENGTH(32), .RESET_PC(0)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  instr_fetch #(.DATA_LENGTH(32), .MEM_LENGTH(24), .RESET_PC(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  // Synchronous-read ROM models
  always_ff @(posedge clk) begin
    bus_a.rom_data <= 32'(bus_a.rom_address) + 32'd100;
    bus_b.rom_data <= 32'(bus_b.rom_address) + 32'd100;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic word_a(input string tag, input int addr);
    check(tag, {26'd0, bus_a.instr_valid, bus_a.instr_address, bus_a.instr_data},
               {26'd0, 1'b1, 5'(addr), 32'(addr + 100)});
  endtask

  task automatic word_b(input string tag, input int addr);
    check(tag, {26'd0, bus_b.instr_valid, bus_b.instr_address, bus_b.instr_data},
               {26'd0, 1'b1, 5'(addr), 32'(addr + 100)});
  endtask

  task automatic reset_state_a(input string tag);
    check(tag, {26'd0, bus_a.instr_valid, bus_a.instr_address, bus_a.instr_data}, 64'd0);
    check({tag, "_rom"}, 64'(bus_a.rom_address), 64'd0);
  endtask

  initial begin
    bus_a.instr_ready      = 1'b1;
    bus_a.redirect_valid   = 1'b0;
    bus_a.redirect_address = '0;
    bus_b.instr_ready      = 1'b1;
    bus_b.redirect_valid   = 1'b0;
    bus_b.redirect_address = '0;

    // ---------------- reset state ----------------
    repeat (3) step();
    reset_state_a("reset_a");
    check("reset_b_valid", 64'(bus_b.instr_valid), 64'd0);

    // ---------------- startup and streaming with wrap ----------------
    rst = 1'b0;                      // cycle 0
    step();                          // cycle 1
    check("start_c1_valid", 64'(bus_a.instr_valid), 64'd0);
    check("start_c1_rom", 64'(bus_a.rom_address), 64'd1);
    step();                          // cycle 2
    for (int k = 0; k < 34; k++) begin
      word_a("stream_a", k % 32);
      word_b("stream_b", k % 24);
      step();
    end

    // ---------------- reset mid-stream, then back-pressure ----------------
    rst = 1'b1;
    step();
    reset_state_a("midreset_a");
    rst = 1'b0;                      // cycle 0
    step();                          // cycle 1
    check("restart_c1_valid", 64'(bus_a.instr_valid), 64'd0);
    step();                          // cycle 2
    for (int i = 0; i < 5; i++) begin
      word_a("bp_hold", 0);
      check("bp_rom_stall", 64'(bus_a.rom_address), 64'd2);
      bus_a.instr_ready = 1'b0;
      step();
    end
    bus_a.instr_ready = 1'b1;        // cycle 7
    for (int k = 0; k < 6; k++) begin
      word_a("bp_release", k);
      step();
    end

    // ---------------- redirect with a buffered and an in-flight word ----------------
    word_a("pre_redirect", 6);       // R
    bus_a.instr_ready      = 1'b0;
    bus_a.redirect_valid   = 1'b1;
    bus_a.redirect_address = 5'd10;
    step();                          // R+1
    check("redir_r1_valid", 64'(bus_a.instr_valid), 64'd0);
    check("redir_r1_rom", 64'(bus_a.rom_address), 64'd10);
    bus_a.redirect_valid = 1'b0;
    bus_a.instr_ready    = 1'b1;
    step();                          // R+2
    check("redir_r2_valid", 64'(bus_a.instr_valid), 64'd0);
    step();                          // R+3
    word_a("redir_target", 10);
    step();
    word_a("redir_next", 11);
    step();

    // ---------------- redirect coincident with a pop; B out-of-range target ----------------
    word_a("pop_redirect", 12);      // popped in this cycle
    bus_a.redirect_valid   = 1'b1;
    bus_a.redirect_address = 5'd3;
    bus_b.redirect_valid   = 1'b1;
    bus_b.redirect_address = 5'd26;  // beyond MEM_LENGTH=24 -> 0
    step();
    check("popredir_r1_valid", 64'(bus_a.instr_valid), 64'd0);
    check("popredir_r1_rom", 64'(bus_a.rom_address), 64'd3);
    check("oor_redir_rom_b", 64'(bus_b.rom_address), 64'd0);
    bus_a.redirect_valid = 1'b0;
    bus_b.redirect_valid = 1'b0;
    step();
    check("popredir_r2_valid", 64'(bus_a.instr_valid), 64'd0);
    check("oor_r2_valid_b", 64'(bus_b.instr_valid), 64'd0);
    step();
    word_a("popredir_target", 3);
    word_b("oor_target_b", 0);

    // ---------------- redirect to the last address, then wrap ----------------
    bus_a.redirect_valid   = 1'b1;
    bus_a.redirect_address = 5'd31;
    step();
    check("last_r1_rom", 64'(bus_a.rom_address), 64'd31);
    bus_a.redirect_valid = 1'b0;
    step();
    step();
    word_a("last_target", 31);
    step();
    word_a("last_wrap", 0);
    bus_a.instr_ready = 1'b0;        // let the FIFO fill to two
    step();
    word_a("fill_hold", 0);

    // ---------------- reset with a full FIFO ----------------
    rst = 1'b1;
    step();
    reset_state_a("fullreset_a");
    bus_a.instr_ready = 1'b1;
    rst = 1'b0;                      // cycle 0
    step();                          // cycle 1
    check("restart2_c1_valid", 64'(bus_a.instr_valid), 64'd0);
    step();                          // cycle 2
    word_a("restart2_c2", 0);
    step();
    word_a("restart2_c3", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
